// File: rtl/decode_family_queue.sv
// Classifies ARMv4 instructions into decode families and buffers them, with the
// decoded family, in a DEPTH-entry valid/ready FIFO. Also keeps a saturating
// count of undefined/unsupported pushes.
module decode_family_queue #(
    parameter int DEPTH     = 4,
    parameter int COPROC_EN = 1,
    parameter int CNT_W     = 16,
    localparam int FW       = (COPROC_EN != 0) ? 20 : 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ir,
    output logic [FW-1:0]    out_f_signals,
    output logic [4:0]       out_f_num,
    output logic             out_none,
    output logic [CNT_W-1:0] undef_count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]      irMem_q   [DEPTH];
    logic [4:0]       numMem_q  [DEPTH];
    logic             noneMem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] undef_q, undef_d;

    logic [4:0] decNum;
    logic       decNone;
    logic       push, pop;

    // First-match family decode keyed on bits[27:25].
    always_comb begin
        decNum  = 5'd0;
        decNone = 1'b0;
        case (in_ir[27:25])
            3'b000: begin
                if (in_ir[24:22] == 3'b000 && in_ir[7:4] == 4'b1001)
                    decNum = 5'd3;
                else if (in_ir[24:23] == 2'b01 && in_ir[7:4] == 4'b1001)
                    decNum = 5'd4;
                else if (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b00)
                    decNum = (in_ir[7:4] == 4'b1001) ? 5'd12 : 5'd5;
                else if (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b10 && !in_ir[4])
                    decNum = 5'd7;
                else if (!in_ir[4])
                    decNum = 5'd1;
                else if (!in_ir[7])
                    decNum = 5'd2;
                else
                    decNum = in_ir[22] ? 5'd10 : 5'd11;
            end
            3'b001:  decNum = (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b10) ? 5'd6 : 5'd0;
            3'b010:  decNum = 5'd8;
            3'b011:  decNum = in_ir[4] ? 5'd15 : 5'd9;
            3'b100:  decNum = 5'd13;
            3'b101:  decNum = 5'd14;
            3'b110: begin
                if (COPROC_EN != 0) decNum = 5'd18;
                else                decNone = 1'b1;
            end
            default: begin
                if (COPROC_EN == 0) decNone = 1'b1;
                else if (in_ir[24]) decNum = 5'd19;
                else if (!in_ir[4]) decNum = 5'd16;
                else                decNum = 5'd17;
            end
        endcase
    end

    assign in_ready  = (count_q != (AW+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_ir        = irMem_q[rdPtr_q];
    assign out_f_num     = numMem_q[rdPtr_q];
    assign out_none      = noneMem_q[rdPtr_q];
    assign out_f_signals = noneMem_q[rdPtr_q] ? '0 : (FW'(1) << numMem_q[rdPtr_q]);
    assign undef_count   = undef_q;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        undef_d = undef_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + AW'(1);
            if (pop)  rdPtr_d = rdPtr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);
        end
        if (push && (decNone || decNum == 5'd15) && undef_q != '1)
            undef_d = undef_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            undef_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            undef_q <= undef_d;
        end
    end

    // Storage is deliberately left unreset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            irMem_q[wrPtr_q]   <= in_ir;
            numMem_q[wrPtr_q]  <= decNum;
            noneMem_q[wrPtr_q] <= decNone;
        end
    end
endmodule

// File: tb/tb_decode_family_queue.sv
// Randomised and directed bench for decode_family_queue: two instances (coprocessor
// on with wide counter, coprocessor off with 2-bit counter) checked against a queue model.
module tb_decode_family_queue;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_ir;
    logic        out_ready;

    logic        inReadyA, outValidA, outNoneA;
    logic [31:0] outIrA;
    logic [19:0] fSigA;
    logic [4:0]  fNumA;
    logic [15:0] undefA;

    logic        inReadyB, outValidB, outNoneB;
    logic [31:0] outIrB;
    logic [15:0] fSigB;
    logic [4:0]  fNumB;
    logic [1:0]  undefB;

    int passedChecks = 0;
    int totalChecks  = 0;
    bit modelReady   = 0;

    logic [31:0] qA[$];
    logic [31:0] qB[$];
    int          cntA, cntB;

    decode_family_queue #(.DEPTH(4), .COPROC_EN(1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(inReadyA), .in_ir(in_ir), .out_valid(outValidA),
        .out_ready(out_ready), .out_ir(outIrA), .out_f_signals(fSigA),
        .out_f_num(fNumA), .out_none(outNoneA), .undef_count(undefA)
    );

    decode_family_queue #(.DEPTH(4), .COPROC_EN(0), .CNT_W(2)) dutB (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(inReadyB), .in_ir(in_ir), .out_valid(outValidB),
        .out_ready(out_ready), .out_ir(outIrB), .out_f_signals(fSigB),
        .out_f_num(fNumB), .out_none(outNoneB), .undef_count(undefB)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Family table from the ARMv4 decode rules; -1 means no family.
    function automatic int familyOf(logic [31:0] ir, bit coproc);
        case (ir[27:25])
            3'b000: begin
                if (ir[24:22] == 3'b000 && ir[7:4] == 4'b1001) return 3;
                if (ir[24:23] == 2'b01 && ir[7:4] == 4'b1001) return 4;
                if (ir[24:23] == 2'b10 && ir[21:20] == 2'b00) return (ir[7:4] == 4'b1001) ? 12 : 5;
                if (ir[24:23] == 2'b10 && ir[21:20] == 2'b10 && ir[4] == 1'b0) return 7;
                if (ir[4] == 1'b0) return 1;
                if (ir[7] == 1'b0) return 2;
                return (ir[22] == 1'b0) ? 11 : 10;
            end
            3'b001:  return (ir[24:23] == 2'b10 && ir[21:20] == 2'b10) ? 6 : 0;
            3'b010:  return 8;
            3'b011:  return (ir[4] == 1'b0) ? 9 : 15;
            3'b100:  return 13;
            3'b101:  return 14;
            3'b110:  return coproc ? 18 : -1;
            default: begin
                if (!coproc) return -1;
                if (ir[24]) return 19;
                return (ir[4] == 1'b0) ? 16 : 17;
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) passedChecks++;
        else $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    endtask

    // Reference queues advance on each edge from the inputs held across it.
    always @(posedge clk) begin
        int  fam;
        bit  doPush, doPop;
        if (!rst_n) begin
            qA.delete(); qB.delete();
            cntA = 0; cntB = 0;
            modelReady = 1;
        end else if (flush) begin
            qA.delete(); qB.delete();
        end else begin
            doPush = in_valid && (qA.size() < 4);
            doPop  = out_ready && (qA.size() > 0);
            if (doPop) void'(qA.pop_front());
            if (doPush) begin
                qA.push_back(in_ir);
                fam = familyOf(in_ir, 1'b1);
                if ((fam == 15 || fam < 0) && cntA < 65535) cntA++;
            end
            doPush = in_valid && (qB.size() < 4);
            doPop  = out_ready && (qB.size() > 0);
            if (doPop) void'(qB.pop_front());
            if (doPush) begin
                qB.push_back(in_ir);
                fam = familyOf(in_ir, 1'b0);
                if ((fam == 15 || fam < 0) && cntB < 3) cntB++;
            end
        end
    end

    always @(negedge clk) begin
        int fam;
        if (modelReady) begin
            checkOutput("A in_ready", 32'(inReadyA), 32'(qA.size() < 4));
            checkOutput("A out_valid", 32'(outValidA), 32'(qA.size() > 0));
            checkOutput("A undef_count", 32'(undefA), 32'(cntA));
            if (qA.size() > 0) begin
                fam = familyOf(qA[0], 1'b1);
                checkOutput("A out_ir", outIrA, qA[0]);
                checkOutput("A f_num", 32'(fNumA), (fam < 0) ? 32'd0 : 32'(fam));
                checkOutput("A none", 32'(outNoneA), 32'(fam < 0));
                checkOutput("A f_signals", 32'(fSigA), (fam < 0) ? 32'd0 : (32'd1 << fam));
            end
            checkOutput("B in_ready", 32'(inReadyB), 32'(qB.size() < 4));
            checkOutput("B out_valid", 32'(outValidB), 32'(qB.size() > 0));
            checkOutput("B undef_count", 32'(undefB), 32'(cntB));
            if (qB.size() > 0) begin
                fam = familyOf(qB[0], 1'b0);
                checkOutput("B out_ir", outIrB, qB[0]);
                checkOutput("B f_num", 32'(fNumB), (fam < 0) ? 32'd0 : 32'(fam));
                checkOutput("B none", 32'(outNoneB), 32'(fam < 0));
                checkOutput("B f_signals", 32'(fSigB), (fam < 0) ? 32'd0 : (32'd1 << fam));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic rdy, input logic fl);
        in_valid  = v;
        in_ir     = ir;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sweepIr  [9] = '{32'hE0810002, 32'hE0000091, 32'hE10F0000, 32'hE1010092,
                                  32'hE1D000B0, 32'hE5910000, 32'hE7900010, 32'hEA000000,
                                  32'hEF000000};
    int          sweepNum [9] = '{1, 3, 5, 12, 10, 8, 15, 14, 19};

    initial begin
        int savedA, savedB;
        rst_n = 0; flush = 0; in_valid = 0; in_ir = '0; out_ready = 0;
        applyStimulus(0, 32'h0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0);
        rst_n = 1;
        checkOutput("reset in_ready", 32'(inReadyA), 32'd1);
        checkOutput("reset out_valid", 32'(outValidA), 32'd0);
        checkOutput("reset undef_count", 32'(undefA), 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, sweepIr[i], 1, 0);
            checkOutput("sweep f_num", 32'(fNumA), 32'(sweepNum[i]));
        end
        applyStimulus(0, 32'h0, 1, 0);
        checkOutput("sweep undef A", 32'(undefA), 32'd1);
        checkOutput("sweep undef B", 32'(undefB), 32'd2);

        applyStimulus(1, 32'hEE000010, 1, 0);
        checkOutput("coproc on f_num", 32'(fNumA), 32'd17);
        checkOutput("coproc off none", 32'(outNoneB), 32'd1);
        checkOutput("coproc off f_signals", 32'(fSigB), 32'd0);
        checkOutput("coproc off f_num", 32'(fNumB), 32'd0);
        checkOutput("coproc off undef", 32'(undefB), 32'd3);
        applyStimulus(0, 32'h0, 1, 0);

        for (int i = 0; i < 5; i++) applyStimulus(1, 32'hE7900010, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        checkOutput("saturated undef B", 32'(undefB), 32'd3);
        checkOutput("unsaturated undef A", 32'(undefA), 32'd6);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'hE2800000 + 32'(i), 0, 0);
            if (i == 3) checkOutput("full in_ready", 32'(inReadyA), 32'd0);
        end
        checkOutput("full head", outIrA, 32'hE2800000);
        for (int i = 0; i < 8; i++) applyStimulus(1, $urandom, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 1, 0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 32'hE0810000 + 32'(i), 0, 0);
        savedA = cntA;
        savedB = cntB;
        applyStimulus(1, 32'hE7900010, 1, 1);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("flush out_valid", 32'(outValidA), 32'd0);
        checkOutput("flush in_ready", 32'(inReadyA), 32'd1);
        checkOutput("flush undef A", 32'(undefA), 32'(savedA));
        checkOutput("flush undef B", 32'(undefB), 32'(savedB));

        for (int i = 0; i < 2; i++) applyStimulus(1, 32'hE7900010, 0, 0);
        rst_n = 0;
        applyStimulus(1, 32'hE7900010, 1, 0);
        rst_n = 1;
        checkOutput("midreset out_valid", 32'(outValidA), 32'd0);
        checkOutput("midreset undef A", 32'(undefA), 32'd0);
        checkOutput("midreset undef B", 32'(undefB), 32'd0);

        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);
        applyStimulus(0, 32'h0, 0, 0);

        $display("[TB] %0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end
endmodule

// File: doc/decode_family_queue.md
# decode_family_queue

Registered, parametrised successor to the combinational instruction-family decoder. Classifies each 32-bit ARMv4 instruction into a decode family, stores the result with the instruction in a DEPTH-entry FIFO between fetch and the control sequencer, and uses valid/ready handshakes on both sides. Optionally decodes the coprocessor and SWI space, which the previous decoder reported as "no family". Counts undefined and unsupported instructions for debug.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `COPROC_EN`, 1 — 1: decode bits[27:25] = 11x into families 16–19. 0: those encodings report no family.
- `CNT_W`, 16 — width of the undefined/unsupported counter.
- `FW` (localparam) — 20 if `COPROC_EN`, else 16.

Ports:
- `clk` in 1 — single clock; all state on rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `flush` in 1 — synchronous queue clear (branch redirect).
- `in_valid` in 1 — `in_ir` is valid.
- `in_ready` out 1 — queue can accept an instruction.
- `in_ir` in 32 — instruction word.
- `out_valid` out 1 — head entry is valid.
- `out_ready` in 1 — consumer takes the head entry.
- `out_ir` out 32 — head instruction.
- `out_f_signals` out FW — one-hot family; all zero if no family.
- `out_f_num` out 5 — encoded family; 0 if no family.
- `out_none` out 1 — head matched no family.
- `undef_count` out CNT_W — saturating count of enqueued family-15 and no-family entries.

## Operation
- Decode is combinational on `in_ir`. The result is written into the FIFO with the instruction on push: `push = in_valid & in_ready & ~flush`.
- Family rules, first match wins, keyed on bits[27:25]:
  - 000:
    - [24:22]=000 and [7:4]=1001 → 3.
    - [24:23]=01 and [7:4]=1001 → 4.
    - [24:23]=10 and [21:20]=00 → 12 if [7:4]=1001, else 5.
    - [24:23]=10 and [21:20]=10 and [4]=0 → 7.
    - [4]=0 → 1.
    - [7]=0 → 2.
    - [22]=0 → 11; else 10.
  - 001: [24:23]=10 and [21:20]=10 → 6; else 0.
  - 010 → 8.
  - 011: [4]=0 → 9; else 15.
  - 100 → 13.
  - 101 → 14.
  - 110: 18 (LDC/STC) if `COPROC_EN`, else none.
  - 111: if `COPROC_EN`: [24]=1 → 19 (SWI); [4]=0 → 16 (CDP); else 17 (MCR/MRC). Otherwise none.
- `out_f_signals` = 1 << `f_num` when a family matches, else 0. Family 0 and "none" both give `f_num` = 0; `out_none` tells them apart.
- FIFO:
  - Read/write pointers, log2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy `count`, log2(DEPTH)+1 bits.
  - `pop = out_valid & out_ready & ~flush`.
  - `in_ready = (count != DEPTH)`; registered-state only, no combinational path from `out_ready`.
  - When full, a same-cycle pop does not open `in_ready`.
  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
  - `out_valid = (count != 0)`. Head outputs come straight from the storage entry at the read pointer.
- Flush: pointers and count go to 0 next cycle. A push or pop in the flush cycle is dropped. `undef_count` is not affected.
- Counter: increments by 1 on a push whose decode is family 15 or none. Saturates at all ones.
- Reset (`rst_n` = 0 at an edge):
  - count, pointers, and `undef_count` go to 0; `in_ready` = 1, `out_valid` = 0.
  - Head data outputs are don't-care while `out_valid` = 0. Storage is not reset.
  - Reset overrides flush, push, and pop.

## Timing
- Latency: an instruction pushed at edge t is visible with `out_valid` = 1 after edge t (1 cycle), if the queue was empty.
- Throughput: 1 instruction/cycle while not full and not empty.
- Ordering is strictly FIFO.
- While `out_valid` = 1 and `out_ready` = 0, head outputs hold stable.
- `undef_count` updates on the edge that performs the push.

## Test plan
- **Reset and empty.** Hold `rst_n` = 0 for 2 cycles, then release. Require `in_ready` = 1, `out_valid` = 0, `undef_count` = 0.
- **Family sweep.** With `out_ready` = 1, push E0810002 (ADD), E0000091 (MUL), E10F0000 (MRS), E1010092 (SWP), E1D000B0 (LDRH), E5910000 (LDR), E7900010, EA000000 (B), EF000000.
  - Require `f_num` = 1, 3, 5, 12, 10, 8, 15, 14, 19, each one cycle after its push.
  - Require `undef_count` = 1.
- **Coprocessor off.** Rerun with `COPROC_EN` = 0 and push EE000010. Require `out_none` = 1, `f_signals` = 0, `f_num` = 0, `undef_count` increments.
- **Full and wrap.** Hold `out_ready` = 0 and push DEPTH+1 words.
  - `in_ready` drops after DEPTH pushes; the extra word is not accepted.
  - Then assert `out_ready` and `in_valid` together for 2·DEPTH cycles. Output order matches input order across pointer wrap.
- **Flush mid-stream.** Enqueue 3 entries, assert `flush` with `in_valid` = 1 and `out_ready` = 1.
  - Next cycle `out_valid` = 0 and count = 0; the flush-cycle word is absent.
  - `undef_count` is unchanged.
- **Saturation and mid-run reset.** With `CNT_W` = 2, push 5 undefined words: count holds at 3. Assert reset while 2 entries are queued: next cycle empty, count = 0.
